// File: rtl/card_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : card_reader_pkg
// Description : Shared state encoding, frame layout and parity helper for the
//               smart card reader front end.
// Revision    : 1.0 - initial release
// ============================================================================
package card_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_ISSUE   = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    localparam int FRAME_LEN = 9;
    localparam int LAB_BIT   = 8;
    localparam int MODE_MSB  = 7;
    localparam int CODE_MSB  = 5;
    localparam int PAR_BIT   = 0;

    localparam int          BITCNT_W     = 4;
    localparam logic [3:0]  LAST_BIT_CNT = 4'(FRAME_LEN - 1);

    // Even parity over the whole frame: the payload XOR must equal the parity bit.
    function automatic logic frame_parity_ok(input logic [FRAME_LEN-1:0] frame);
        return (^frame[FRAME_LEN-1:PAR_BIT+1]) == frame[PAR_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/reader_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : reader_gap_timer
// Description : Saturating up-counter with synchronous clear and enable; flags
//               when the count has reached LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module reader_gap_timer #(
    parameter int LIMIT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] C_LIMIT = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != C_LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/smart_card_reader.sv
`default_nettype none
// ============================================================================
// Module      : smart_card_reader
// Description : Deserialises a 9-bit card swipe, checks even parity and issues
//               smartCode/lab/mode for one cycle, with gap timeout and hold-off.
// Revision    : 1.0 - initial release
// ============================================================================
module smart_card_reader
    import card_reader_pkg::*;
#(
    parameter int         TIMEOUT   = 16,
    parameter int         HOLDOFF   = 8,
    parameter logic [1:0] IDLE_MODE = 2'b11
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [4:0] smartCode,
    output logic       lab,
    output logic [1:0] mode,
    output logic       code_valid,
    output logic       parity_err,
    output logic       timeout_err,
    output logic       busy
);

    state_t                 state_q, state_d;
    // Only the first eight bits are stored; the ninth is taken live from bit_in.
    logic [FRAME_LEN-2:0]   shift_q, shift_d;
    logic [BITCNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]             code_q, code_d;
    logic                   lab_q, lab_d;
    logic [1:0]             mode_q, mode_d;
    logic                   code_valid_q, code_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [FRAME_LEN-1:0]   w_frame;
    logic                   w_gap_clear;
    logic                   w_gap_en;
    logic                   w_gap_expired;
    logic                   w_hold_clear;
    logic                   w_hold_en;
    logic                   w_hold_expired;

    assign w_frame = {shift_q, bit_in};

    assign w_gap_clear = (state_q != S_SHIFT) || bit_valid;
    assign w_gap_en    = (state_q == S_SHIFT) && !bit_valid;

    // The hold-off timer also ticks through ISSUE so that HOLDOFF itself lasts
    // exactly HOLDOFF cycles before IDLE is re-entered.
    assign w_hold_en    = (state_q == S_ISSUE) || (state_q == S_HOLDOFF);
    assign w_hold_clear = !w_hold_en;

    reader_gap_timer #(
        .LIMIT (TIMEOUT)
    ) u_gap_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear_i   (w_gap_clear),
        .en_i      (w_gap_en),
        .expired_o (w_gap_expired)
    );

    reader_gap_timer #(
        .LIMIT (HOLDOFF)
    ) u_hold_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear_i   (w_hold_clear),
        .en_i      (w_hold_en),
        .expired_o (w_hold_expired)
    );

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        code_d        = code_q;
        lab_d         = lab_q;
        mode_d        = IDLE_MODE;
        code_valid_d  = 1'b0;
        parity_err_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bit_valid) begin
                    shift_d = w_frame[FRAME_LEN-2:0];
                    cnt_d   = 4'd1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (bit_valid) begin
                    if (cnt_q == LAST_BIT_CNT) begin
                        cnt_d = '0;
                        if (frame_parity_ok(w_frame)) begin
                            code_d       = w_frame[CODE_MSB -: 5];
                            lab_d        = w_frame[LAB_BIT];
                            mode_d       = w_frame[MODE_MSB -: 2];
                            code_valid_d = 1'b1;
                            state_d      = S_ISSUE;
                        end else begin
                            parity_err_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end else begin
                        shift_d = w_frame[FRAME_LEN-2:0];
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else if (w_gap_expired) begin
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            S_ISSUE: begin
                state_d = S_HOLDOFF;
            end

            S_HOLDOFF: begin
                if (w_hold_expired) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            code_q        <= '0;
            lab_q         <= 1'b0;
            mode_q        <= IDLE_MODE;
            code_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            code_q        <= code_d;
            lab_q         <= lab_d;
            mode_q        <= mode_d;
            code_valid_q  <= code_valid_d;
            parity_err_q  <= parity_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign smartCode   = code_q;
    assign lab         = lab_q;
    assign mode        = mode_q;
    assign code_valid  = code_valid_q;
    assign parity_err  = parity_err_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_smart_card_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_smart_card_reader
// Description : Scoreboard bench for smart_card_reader with a frame-level
//               reference model and randomized swipes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smart_card_reader;

    localparam int TIMEOUT = 16;
    localparam int HOLDOFF = 8;
    localparam int EV_CODE = 0;
    localparam int EV_PAR  = 1;
    localparam int EV_TO   = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [4:0] smartCode;
    logic       lab;
    logic [1:0] mode;
    logic       code_valid;
    logic       parity_err;
    logic       timeout_err;
    logic       busy;

    always #5 CLK = ~CLK;

    smart_card_reader #(
        .TIMEOUT   (TIMEOUT),
        .HOLDOFF   (HOLDOFF),
        .IDLE_MODE (2'b11)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .smartCode   (smartCode),
        .lab         (lab),
        .mode        (mode),
        .code_valid  (code_valid),
        .parity_err  (parity_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    typedef struct {
        int         due;
        int         kind;
        logic [1:0] mode;
    } ev_t;

    ev_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bits collected so far, idle gap, cycles still ignored.
    int         edge_cnt = 0;
    int         m_nb     = 0;
    int         m_gap    = 0;
    int         m_ign    = 0;
    logic [8:0] m_sh     = '0;
    logic [4:0] m_code   = '0;
    logic       m_lab    = 1'b0;

    task automatic push_ev(input int kind, input logic [1:0] md);
        ev_t e;
        e.due  = edge_cnt;
        e.kind = kind;
        e.mode = md;
        exp_q.push_back(e);
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_nb   = 0;
            m_gap  = 0;
            m_ign  = 0;
            m_code = '0;
            m_lab  = 1'b0;
            exp_q.delete();
        end else begin
            edge_cnt++;
            if (m_ign > 0) begin
                m_ign--;
            end else if (bit_valid) begin
                m_sh  = {m_sh[7:0], bit_in};
                m_nb++;
                m_gap = 0;
                if (m_nb == 9) begin
                    m_nb = 0;
                    if ((^m_sh) == 1'b0) begin
                        m_lab  = m_sh[8];
                        m_code = m_sh[5:1];
                        m_ign  = 1 + HOLDOFF;
                        push_ev(EV_CODE, m_sh[7:6]);
                    end else begin
                        push_ev(EV_PAR, 2'b11);
                    end
                end
            end else if (m_nb > 0) begin
                if (m_gap == TIMEOUT) begin
                    m_nb  = 0;
                    m_gap = 0;
                    push_ev(EV_TO, 2'b11);
                end else begin
                    m_gap++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic       mon_has;
    int         mon_kind;
    logic [1:0] mon_mode;

    always @(posedge CLK) begin
        #1;
        if (!RST_N) begin
            chk("reset_outputs",
                {smartCode, lab, mode, code_valid, parity_err, timeout_err, busy},
                {5'd0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
        end else begin
            mon_has  = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
            mon_kind = mon_has ? exp_q[0].kind : -1;
            mon_mode = (mon_kind == EV_CODE) ? exp_q[0].mode : 2'b11;
            chk("pulses", {code_valid, parity_err, timeout_err},
                {mon_kind == EV_CODE, mon_kind == EV_PAR, mon_kind == EV_TO});
            chk("mode", mode, mon_mode);
            chk("held_code_lab", {smartCode, lab}, {m_code, m_lab});
            chk("busy", busy, (m_nb > 0) || (m_ign > 0));
            if (mon_has) void'(exp_q.pop_front());
        end
    end

    task automatic drive(input logic v, input logic b);
        @(negedge CLK);
        bit_valid = v;
        bit_in    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [8:0] f);
        for (int i = 8; i >= 0; i--) drive(1'b1, f[i]);
    endtask

    function automatic logic [8:0] make_frame(input logic l, input logic [1:0] md,
                                             input logic [4:0] code, input logic flip);
        logic [8:0] f;
        f    = {l, md, code, 1'b0};
        f[0] = (^f[8:1]) ^ flip;
        return f;
    endfunction

    task automatic pulse_reset();
        @(negedge CLK);
        RST_N     = 1'b0;
        bit_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] f;
        int         g;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        idle(20);

        // Reference frame from the card format description.
        send_frame(9'b001110010);
        idle(2);
        chk("direct_code", {smartCode, lab}, {5'b11001, 1'b0});
        idle(15);
        send_frame(9'b001110011);
        idle(5);
        chk("direct_hold_after_bad", {smartCode, lab, mode}, {5'b11001, 1'b0, 2'b11});

        // Gap timeout, then recovery.
        f = make_frame(1'b1, 2'b10, 5'b10110, 1'b0);
        for (int i = 8; i >= 5; i--) drive(1'b1, f[i]);
        idle(TIMEOUT + 1);
        idle(3);
        send_frame(f);
        idle(12);

        // A bit arriving exactly at the timeout limit is still accepted.
        f = make_frame(1'b0, 2'b00, 5'b01011, 1'b0);
        for (int i = 8; i >= 5; i--) drive(1'b1, f[i]);
        idle(TIMEOUT);
        for (int i = 4; i >= 0; i--) drive(1'b1, f[i]);
        idle(12);

        // Double swipe inside the hold-off, then just after it.
        f = make_frame(1'b1, 2'b01, 5'b00011, 1'b0);
        send_frame(f);
        idle(3);
        send_frame(f);
        idle(30);
        send_frame(f);
        idle(HOLDOFF + 1);
        send_frame(make_frame(1'b0, 2'b10, 5'b11100, 1'b0));
        idle(12);

        // Reset mid-frame, then a fresh frame.
        f = make_frame(1'b0, 2'b10, 5'b10101, 1'b0);
        for (int i = 8; i >= 4; i--) drive(1'b1, f[i]);
        pulse_reset();
        idle(2);
        send_frame(9'b100001110);
        idle(3);
        chk("direct_after_reset", {smartCode, lab}, {5'b00111, 1'b1});
        idle(12);

        for (int n = 0; n < 300; n++) begin
            f = make_frame(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0));
            for (int i = 8; i >= 0; i--) begin
                drive(1'b1, f[i]);
                g = $urandom_range(0, 19);
                if (g < 12) idle(0);
                else if (g < 17) idle($urandom_range(1, 3));
                else idle($urandom_range(TIMEOUT - 1, TIMEOUT + 2));
                if ($urandom_range(0, 199) == 0) pulse_reset();
            end
            idle($urandom_range(0, 12));
        end

        idle(30);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
